// File: rtl/oled_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : oled_init_seq
// Purpose  : Owns the OLED SPI byte-writer. After reset it pulses the panel
//            hardware reset, waits for the panel to settle, then streams the
//            fixed 25-entry SSD1306 init table through the writer's
//            DATA/START/DONE handshake. Once init is done it grants
//            single-byte command/data writes to one upstream requester.
//            Every transaction is presented as {CS=0, DC, byte}; SCLK is
//            never touched here.
// Build    : define OLED_CLEAR_SCREEN_EN to append a full GDDRAM clear
//            (8 pages x {B0+p, 00, 10, 128 x data 00}) after the init table.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK        in   1   system clock
//   RST_N      in   1   asynchronous active-low reset
//   SPI_DATA   out  10  to writer: [9]=CS (0 in a transaction, 1 idle),
//                       [8]=DC, [7:0]=byte
//   SPI_START  out  1   one-cycle start pulse to writer
//   SPI_DONE   in   1   one-cycle completion pulse from writer
//   OLED_RES   out  1   panel hardware reset, active low
//   READY      out  1   high once init (and optional clear) has finished
//   WR_REQ     in   1   user write request (level), honoured in the idle state
//   WR_DC      in   1   user DC bit: 0=command, 1=data
//   WR_BYTE    in   8   user byte
//   WR_ACK     out  1   one-cycle pulse on the SPI_DONE cycle of a user write
//   BUSY       out  1   high whenever a writer transaction is outstanding
// ============================================================================
module oled_init_seq #(
    parameter int RES_LOW_CYC  = 250,
    parameter int RES_WAIT_CYC = 250,
    parameter int CMD_NUM      = 25
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [9:0] SPI_DATA,
    output logic       SPI_START,
    input  logic       SPI_DONE,
    output logic       OLED_RES,
    output logic       READY,
    input  logic       WR_REQ,
    input  logic       WR_DC,
    input  logic [7:0] WR_BYTE,
    output logic       WR_ACK,
    output logic       BUSY
);

    localparam logic [3:0] S_RES_LOW   = 4'd0;
    localparam logic [3:0] S_RES_WAIT  = 4'd1;
    localparam logic [3:0] S_INIT_LOAD = 4'd2;
    localparam logic [3:0] S_INIT_WAIT = 4'd3;
    localparam logic [3:0] S_READY     = 4'd4;
    localparam logic [3:0] S_USER_LOAD = 4'd5;
    localparam logic [3:0] S_USER_WAIT = 4'd6;

    localparam logic [15:0] RES_LOW_LAST  = 16'(RES_LOW_CYC - 1);
    localparam logic [15:0] RES_WAIT_LAST = 16'(RES_WAIT_CYC - 1);
    localparam logic [4:0]  LAST_IDX      = 5'(CMD_NUM - 1);

    logic [3:0]  state;
    logic [15:0] delay_cnt;
    logic [4:0]  idx;
    logic [8:0]  user_word;   // latched {DC, byte} of the user write in flight
    logic [7:0]  init_byte;

`ifdef OLED_CLEAR_SCREEN_EN
    localparam logic [3:0] S_CLR_LOAD   = 4'd7;
    localparam logic [3:0] S_CLR_WAIT   = 4'd8;
    // Per page: columns 0..2 carry the three addressing commands,
    // columns 3..130 carry the 128 zero data bytes.
    localparam logic [7:0] CLR_LAST_COL = 8'd130;

    logic [2:0] page;
    logic [7:0] col;
    logic [8:0] clr_word;

    always_comb begin
        clr_word = 9'h100;
        case (col)
            8'd0:    clr_word = {1'b0, 5'b10110, page};  // B0 + page
            8'd1:    clr_word = 9'h000;                  // lower column = 0
            8'd2:    clr_word = 9'h010;                  // upper column = 0
            default: clr_word = 9'h100;
        endcase
    end
`endif

    // SSD1306 power-up command table
    always_comb begin
        init_byte = 8'h00;
        case (idx)
            5'd0:    init_byte = 8'hAE;
            5'd1:    init_byte = 8'hD5;
            5'd2:    init_byte = 8'h80;
            5'd3:    init_byte = 8'hA8;
            5'd4:    init_byte = 8'h3F;
            5'd5:    init_byte = 8'hD3;
            5'd6:    init_byte = 8'h00;
            5'd7:    init_byte = 8'h40;
            5'd8:    init_byte = 8'h8D;
            5'd9:    init_byte = 8'h14;
            5'd10:   init_byte = 8'h20;
            5'd11:   init_byte = 8'h02;
            5'd12:   init_byte = 8'hA1;
            5'd13:   init_byte = 8'hC8;
            5'd14:   init_byte = 8'hDA;
            5'd15:   init_byte = 8'h12;
            5'd16:   init_byte = 8'h81;
            5'd17:   init_byte = 8'hCF;
            5'd18:   init_byte = 8'hD9;
            5'd19:   init_byte = 8'hF1;
            5'd20:   init_byte = 8'hDB;
            5'd21:   init_byte = 8'h40;
            5'd22:   init_byte = 8'hA4;
            5'd23:   init_byte = 8'hA6;
            5'd24:   init_byte = 8'hAF;
            default: init_byte = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_RES_LOW;
            delay_cnt <= 16'd0;
            idx       <= 5'd0;
            user_word <= 9'd0;
`ifdef OLED_CLEAR_SCREEN_EN
            page      <= 3'd0;
            col       <= 8'd0;
`endif
        end else begin
            case (state)
                S_RES_LOW: begin
                    if (delay_cnt == RES_LOW_LAST) begin
                        delay_cnt <= 16'd0;
                        state     <= S_RES_WAIT;
                    end else begin
                        delay_cnt <= delay_cnt + 16'd1;
                    end
                end
                S_RES_WAIT: begin
                    if (delay_cnt == RES_WAIT_LAST) begin
                        delay_cnt <= 16'd0;
                        state     <= S_INIT_LOAD;
                    end else begin
                        delay_cnt <= delay_cnt + 16'd1;
                    end
                end
                S_INIT_LOAD: state <= S_INIT_WAIT;
                S_INIT_WAIT: begin
                    if (SPI_DONE) begin
                        if (idx == LAST_IDX) begin
`ifdef OLED_CLEAR_SCREEN_EN
                            page  <= 3'd0;
                            col   <= 8'd0;
                            state <= S_CLR_LOAD;
`else
                            state <= S_READY;
`endif
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= S_INIT_LOAD;
                        end
                    end
                end
`ifdef OLED_CLEAR_SCREEN_EN
                S_CLR_LOAD: state <= S_CLR_WAIT;
                S_CLR_WAIT: begin
                    if (SPI_DONE) begin
                        if (col == CLR_LAST_COL) begin
                            col <= 8'd0;
                            if (page == 3'd7) begin
                                state <= S_READY;
                            end else begin
                                page  <= page + 3'd1;
                                state <= S_CLR_LOAD;
                            end
                        end else begin
                            col   <= col + 8'd1;
                            state <= S_CLR_LOAD;
                        end
                    end
                end
`endif
                S_READY: begin
                    if (WR_REQ) begin
                        user_word <= {WR_DC, WR_BYTE};
                        state     <= S_USER_LOAD;
                    end
                end
                S_USER_LOAD: state <= S_USER_WAIT;
                S_USER_WAIT: begin
                    if (SPI_DONE) begin
                        state <= S_READY;
                    end
                end
                default: state <= S_RES_LOW;
            endcase
        end
    end

    // Writer-facing outputs are decoded from state so DATA is valid in the
    // same cycle as START and stays put for the whole wait.
    always_comb begin
        SPI_DATA  = 10'h200;
        SPI_START = 1'b0;
        BUSY      = 1'b0;
        case (state)
            S_INIT_LOAD: begin
                SPI_DATA  = {2'b00, init_byte};
                SPI_START = 1'b1;
                BUSY      = 1'b1;
            end
            S_INIT_WAIT: begin
                SPI_DATA  = {2'b00, init_byte};
                BUSY      = 1'b1;
            end
            S_USER_LOAD: begin
                SPI_DATA  = {1'b0, user_word};
                SPI_START = 1'b1;
                BUSY      = 1'b1;
            end
            S_USER_WAIT: begin
                SPI_DATA  = {1'b0, user_word};
                BUSY      = 1'b1;
            end
`ifdef OLED_CLEAR_SCREEN_EN
            S_CLR_LOAD: begin
                SPI_DATA  = {1'b0, clr_word};
                SPI_START = 1'b1;
                BUSY      = 1'b1;
            end
            S_CLR_WAIT: begin
                SPI_DATA  = {1'b0, clr_word};
                BUSY      = 1'b1;
            end
`endif
            default: begin
                SPI_DATA  = 10'h200;
                SPI_START = 1'b0;
                BUSY      = 1'b0;
            end
        endcase
    end

    assign OLED_RES = (state != S_RES_LOW);
    // User-write states are only reachable after init, so READY stays high
    // across them.
    assign READY    = (state == S_READY) || (state == S_USER_LOAD) ||
                      (state == S_USER_WAIT);
    assign WR_ACK   = (state == S_USER_WAIT) && SPI_DONE;

endmodule
`default_nettype wire

// File: tb/tb_oled_init_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_oled_init_seq
// Purpose  : Self-checking bench for oled_init_seq. A writer model answers
//            each START with DONE 20 cycles later; a monitor logs every
//            transaction word and counts WR_ACK pulses.
// Build    : define OLED_CLEAR_SCREEN_EN to check the GDDRAM clear pass.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oled_init_seq;

    localparam int RES_LOW  = 4;
    localparam int RES_WAIT = 3;
    localparam int WR_LAT   = 20;
    localparam int LIMIT    = 40000;
`ifdef OLED_CLEAR_SCREEN_EN
    localparam int EXP_TXN  = 25 + 1048;
`else
    localparam int EXP_TXN  = 25;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       SPI_DONE = 1'b0;
    logic       WR_REQ = 1'b0;
    logic       WR_DC = 1'b0;
    logic [7:0] WR_BYTE = 8'h00;
    logic [9:0] SPI_DATA;
    logic       SPI_START;
    logic       OLED_RES;
    logic       READY;
    logic       WR_ACK;
    logic       BUSY;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_pending = 0;
    int protocol_err = 0;
    int ack_cnt = 0;
    logic [9:0] txn_log[$];

    logic [7:0] init_tab [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

    oled_init_seq #(
        .RES_LOW_CYC  (RES_LOW),
        .RES_WAIT_CYC (RES_WAIT),
        .CMD_NUM      (25)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SPI_DATA  (SPI_DATA),
        .SPI_START (SPI_START),
        .SPI_DONE  (SPI_DONE),
        .OLED_RES  (OLED_RES),
        .READY     (READY),
        .WR_REQ    (WR_REQ),
        .WR_DC     (WR_DC),
        .WR_BYTE   (WR_BYTE),
        .WR_ACK    (WR_ACK),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // Writer model: DONE for one cycle, WR_LAT cycles after START is seen.
    always @(negedge CLK) begin
        SPI_DONE = 1'b0;
        if (RST_N !== 1'b1) begin
            wr_pending = 0;
        end else if (wr_pending > 0) begin
            if (SPI_START === 1'b1) protocol_err++;
            wr_pending--;
            if (wr_pending == 0) SPI_DONE = 1'b1;
        end else if (SPI_START === 1'b1) begin
            wr_pending = WR_LAT;
        end
    end

    // Transaction / acknowledge monitor.
    always begin
        @(negedge CLK);
        #1;
        if (RST_N === 1'b1) begin
            if (WR_ACK === 1'b1) ack_cnt++;
            if (SPI_START === 1'b1) txn_log.push_back(SPI_DATA);
        end
    end

    task automatic step();
        @(negedge CLK);
        #2;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) step();
        n_cmp++; if (SPI_DATA !== 10'h200) begin n_fail++; $display("FAIL rst_spi_data got=%h exp=200", SPI_DATA); end
        n_cmp++; if (SPI_START !== 1'b0) begin n_fail++; $display("FAIL rst_spi_start got=%b exp=0", SPI_START); end
        n_cmp++; if (OLED_RES !== 1'b0) begin n_fail++; $display("FAIL rst_oled_res got=%b exp=0", OLED_RES); end
        n_cmp++; if (READY !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", READY); end
        n_cmp++; if (WR_ACK !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ack got=%b exp=0", WR_ACK); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    endtask

    // Releases reset and measures the OLED_RES pulse and the settle delay.
    task automatic test_res_timing(input string tag);
        int edges;
        RST_N = 1'b1;
        edges = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (OLED_RES === 1'b1) begin edges = k; break; end
        end
        n_cmp++; if (edges != RES_LOW) begin n_fail++; $display("FAIL %s_res_low_cycles got=%0d exp=%0d", tag, edges, RES_LOW); end
        edges = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (SPI_START === 1'b1) begin edges = k; break; end
        end
        n_cmp++; if (edges != RES_WAIT) begin n_fail++; $display("FAIL %s_first_start_delay got=%0d exp=%0d", tag, edges, RES_WAIT); end
        n_cmp++; if (SPI_DATA !== 10'h0AE) begin n_fail++; $display("FAIL %s_first_cmd got=%h exp=0ae", tag, SPI_DATA); end
        n_cmp++; if (OLED_RES !== 1'b1) begin n_fail++; $display("FAIL %s_res_high got=%b exp=1", tag, OLED_RES); end
    endtask

    task automatic test_init_stream();
        int bad;
        for (int i = 0; i < LIMIT; i++) begin
            step();
            if (READY === 1'b1) break;
        end
        n_cmp++; if (READY !== 1'b1) begin n_fail++; $display("FAIL init_ready_timeout got=%b exp=1", READY); end
        n_cmp++; if (txn_log.size() != EXP_TXN) begin n_fail++; $display("FAIL init_txn_count got=%0d exp=%0d", txn_log.size(), EXP_TXN); end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (i >= txn_log.size() || txn_log[i] !== {2'b00, init_tab[i]}) begin
                n_fail++;
                $display("FAIL init_cmd_%0d got=%h exp=%h", i, (i < txn_log.size()) ? txn_log[i] : 10'h3FF, {2'b00, init_tab[i]});
            end
        end
        n_cmp++; if (protocol_err != 0) begin n_fail++; $display("FAIL init_start_before_done got=%0d exp=0", protocol_err); end
        n_cmp++; if (ack_cnt != 0) begin n_fail++; $display("FAIL init_spurious_ack got=%0d exp=0", ack_cnt); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL ready_busy got=%b exp=0", BUSY); end
        n_cmp++; if (SPI_DATA !== 10'h200) begin n_fail++; $display("FAIL ready_idle_data got=%h exp=200", SPI_DATA); end
`ifdef OLED_CLEAR_SCREEN_EN
        if (txn_log.size() == EXP_TXN) begin
            n_cmp++; if (txn_log[25 + 3*131 + 0] !== 10'h0B3) begin n_fail++; $display("FAIL clr_page3_cmd0 got=%h exp=0b3", txn_log[25 + 3*131]); end
            n_cmp++; if (txn_log[25 + 3*131 + 1] !== 10'h000) begin n_fail++; $display("FAIL clr_page3_cmd1 got=%h exp=000", txn_log[25 + 3*131 + 1]); end
            n_cmp++; if (txn_log[25 + 3*131 + 2] !== 10'h010) begin n_fail++; $display("FAIL clr_page3_cmd2 got=%h exp=010", txn_log[25 + 3*131 + 2]); end
            bad = 0;
            for (int p = 0; p < 8; p++) begin
                if (txn_log[25 + p*131] !== (10'h0B0 + 10'(p))) bad++;
                for (int c = 3; c < 131; c++) begin
                    if (txn_log[25 + p*131 + c] !== 10'h100) bad++;
                end
            end
            n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL clr_words bad=%0d exp=0", bad); end
        end
`endif
    endtask

    task automatic test_user_write();
        int log0;
        int ack0;
        int waited;
        log0 = txn_log.size();
        ack0 = ack_cnt;
        WR_REQ = 1'b1; WR_DC = 1'b1; WR_BYTE = 8'h5A;
        step();
        WR_REQ = 1'b0; WR_DC = 1'b0; WR_BYTE = 8'h00;
        n_cmp++; if (SPI_START !== 1'b1) begin n_fail++; $display("FAIL user_start got=%b exp=1", SPI_START); end
        n_cmp++; if (SPI_DATA !== 10'h15A) begin n_fail++; $display("FAIL user_data got=%h exp=15a", SPI_DATA); end
        n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL user_busy got=%b exp=1", BUSY); end
        waited = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (WR_ACK === 1'b1) begin waited = k; break; end
        end
        n_cmp++; if (waited != WR_LAT) begin n_fail++; $display("FAIL user_ack_latency got=%0d exp=%0d", waited, WR_LAT); end
        n_cmp++; if (SPI_DATA !== 10'h15A) begin n_fail++; $display("FAIL user_data_held got=%h exp=15a", SPI_DATA); end
        step();
        n_cmp++; if (WR_ACK !== 1'b0) begin n_fail++; $display("FAIL user_ack_width got=%b exp=0", WR_ACK); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL user_busy_after got=%b exp=0", BUSY); end
        n_cmp++; if (READY !== 1'b1) begin n_fail++; $display("FAIL user_ready_after got=%b exp=1", READY); end
        repeat (4) step();
        n_cmp++; if (ack_cnt - ack0 != 1) begin n_fail++; $display("FAIL user_ack_count got=%0d exp=1", ack_cnt - ack0); end
        n_cmp++; if (txn_log.size() - log0 != 1) begin n_fail++; $display("FAIL user_txn_count got=%0d exp=1", txn_log.size() - log0); end
    endtask

    task automatic test_mid_reset();
        int ack0;
        RST_N = 1'b0;
        step();
        txn_log.delete();
        RST_N = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            step();
            if (txn_log.size() >= 11) break;
        end
        step();
        n_cmp++; if (BUSY !== 1'b1 || SPI_DATA !== 10'h020) begin n_fail++; $display("FAIL mid_in_wait busy=%b data=%h exp busy=1 data=020", BUSY, SPI_DATA); end
        RST_N = 1'b0;
        #1;
        n_cmp++; if (OLED_RES !== 1'b0) begin n_fail++; $display("FAIL mid_oled_res got=%b exp=0", OLED_RES); end
        n_cmp++; if (READY !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", READY); end
        n_cmp++; if (SPI_START !== 1'b0) begin n_fail++; $display("FAIL mid_start got=%b exp=0", SPI_START); end
        n_cmp++; if (SPI_DATA !== 10'h200 || BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_idle data=%h busy=%b exp data=200 busy=0", SPI_DATA, BUSY); end
        // Request held through the whole restart must wait for READY.
        WR_REQ = 1'b1; WR_DC = 1'b0; WR_BYTE = 8'h33;
        ack0 = ack_cnt;
        step();
        txn_log.delete();
        step();
        test_res_timing("restart");
        for (int i = 0; i < LIMIT; i++) begin
            step();
            if (READY === 1'b1) break;
        end
        n_cmp++; if (READY !== 1'b1) begin n_fail++; $display("FAIL restart_ready_timeout got=%b exp=1", READY); end
        n_cmp++; if (txn_log.size() != EXP_TXN) begin n_fail++; $display("FAIL restart_txn_count got=%0d exp=%0d", txn_log.size(), EXP_TXN); end
        n_cmp++; if (ack_cnt != ack0) begin n_fail++; $display("FAIL restart_ack_during_init got=%0d exp=0", ack_cnt - ack0); end
        if (txn_log.size() > 10) begin
            n_cmp++; if (txn_log[10] !== 10'h020) begin n_fail++; $display("FAIL restart_cmd_10 got=%h exp=020", txn_log[10]); end
        end
    endtask

    task automatic test_back_to_back();
        int ack0;
        int gap;
        ack0 = ack_cnt;
        step();
        n_cmp++; if (SPI_START !== 1'b1 || SPI_DATA !== 10'h033) begin n_fail++; $display("FAIL b2b_first start=%b data=%h exp start=1 data=033", SPI_START, SPI_DATA); end
        WR_DC = 1'b1; WR_BYTE = 8'hC3;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (WR_ACK === 1'b1) break;
        end
        n_cmp++; if (SPI_DATA !== 10'h033) begin n_fail++; $display("FAIL b2b_first_held got=%h exp=033", SPI_DATA); end
        gap = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (SPI_START === 1'b1) begin gap = k; break; end
        end
        n_cmp++; if (gap != 2) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=2", gap); end
        n_cmp++; if (SPI_DATA !== 10'h1C3) begin n_fail++; $display("FAIL b2b_second_data got=%h exp=1c3", SPI_DATA); end
        for (int k = 1; k <= 100; k++) begin
            step();
            if (WR_ACK === 1'b1) break;
        end
        WR_REQ = 1'b0; WR_DC = 1'b0; WR_BYTE = 8'h00;
        repeat (6) step();
        n_cmp++; if (ack_cnt - ack0 != 2) begin n_fail++; $display("FAIL b2b_ack_count got=%0d exp=2", ack_cnt - ack0); end
        n_cmp++; if (txn_log.size() != EXP_TXN + 2) begin n_fail++; $display("FAIL b2b_txn_count got=%0d exp=%0d", txn_log.size(), EXP_TXN + 2); end
        n_cmp++; if (protocol_err != 0) begin n_fail++; $display("FAIL b2b_start_before_done got=%0d exp=0", protocol_err); end
    endtask

    initial begin
        test_reset();
        test_res_timing("boot");
        test_init_stream();
        test_user_write();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
